// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between two requesters.
// Each grant performs one latched read or write. Read data comes back with an ack.
// Arbitration is round-robin, or fixed priority to requester 0 when FIXED_PRIO != 0.
// Ports:
//   clk, reset (async, active-low)
//   req0/we0/addr0/wdata0     requester 0 (datapath/CPU)
//   req1/we1/addr1/wdata1     requester 1 (debug/stepping FSM)
//   gnt0/gnt1, ack0/ack1      ownership during ACCESS+DONE; 1-cycle completion pulse
//   rdata                     memory read data, valid while ack0/ack1 is high
//   busy                      high whenever the FSM is not IDLE
//   mem_we/mem_addr/mem_din   registered memory controls
//   mem_dout                  memory read data (1-cycle synchronous latency)
module mem_arbiter #(
   parameter int unsigned SIZE       = 16,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [SIZE-1:0]       wdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [SIZE-1:0]       wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [SIZE-1:0]       rdata,
   output logic                  busy,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [SIZE-1:0]       mem_din,
   input  logic [SIZE-1:0]       mem_dout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  sel, sel_nxt;
   logic                  last, last_nxt;
   logic                  grant;
   logic                  win;

   logic                  gnt0_nxt, gnt1_nxt, ack0_nxt, ack1_nxt, busy_nxt;
   logic                  mem_we_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr_nxt;
   logic [SIZE-1:0]       mem_din_nxt;

   // State register; outputs are registered from their next-cycle decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         sel      <= 1'b0;
         last     <= 1'b1;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         busy     <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         last     <= last_nxt;
         gnt0     <= gnt0_nxt;
         gnt1     <= gnt1_nxt;
         ack0     <= ack0_nxt;
         ack1     <= ack1_nxt;
         busy     <= busy_nxt;
         mem_we   <= mem_we_nxt;
         mem_addr <= mem_addr_nxt;
         mem_din  <= mem_din_nxt;
      end
   end

   // Next state and arbitration; requests are only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      last_nxt  = last;
      grant     = 1'b0;
      win       = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant = 1'b1;
               if (req0 && req1)
                  win = (FIXED_PRIO != 0) ? 1'b0 : ~last;
               else
                  win = req1;
               sel_nxt   = win;
               last_nxt  = win;
               state_nxt = ACCESS;
            end
         end
         ACCESS:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode for the coming cycle; memory controls latch only on a grant.
   always_comb begin
      gnt0_nxt     = 1'b0;
      gnt1_nxt     = 1'b0;
      ack0_nxt     = 1'b0;
      ack1_nxt     = 1'b0;
      busy_nxt     = (state_nxt != IDLE);
      mem_we_nxt   = 1'b0;
      mem_addr_nxt = mem_addr;
      mem_din_nxt  = mem_din;
      if (state_nxt != IDLE) begin
         gnt0_nxt = ~sel_nxt;
         gnt1_nxt = sel_nxt;
      end
      if (state_nxt == DONE) begin
         ack0_nxt = ~sel_nxt;
         ack1_nxt = sel_nxt;
      end
      if (grant) begin
         mem_we_nxt   = win ? we1    : we0;
         mem_addr_nxt = win ? addr1  : addr0;
         mem_din_nxt  = win ? wdata1 : wdata0;
      end
   end

   // The memory's registered read output already lines up with the DONE cycle.
   assign rdata = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// dut0 runs round-robin, dut1 runs with FIXED_PRIO=1; each has a small
// write-first synchronous memory model behind it.
module tb_mem_arbiter;

   localparam int unsigned SIZE = 16;
   localparam int unsigned AW   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;

   // round-robin instance
   logic            req0, we0, req1, we1;
   logic [AW-1:0]   addr0, addr1;
   logic [SIZE-1:0] wdata0, wdata1;
   logic            gnt0, gnt1, ack0, ack1, busy, mem_we;
   logic [SIZE-1:0] rdata, mem_din, mem_dout;
   logic [AW-1:0]   mem_addr;

   // fixed-priority instance
   logic            p_req0, p_req1;
   logic            p_gnt0, p_gnt1, p_ack0, p_ack1, p_busy, p_mem_we;
   logic [SIZE-1:0] p_rdata, p_mem_din, p_mem_dout;
   logic [AW-1:0]   p_mem_addr;

   mem_arbiter #(.SIZE(SIZE), .ADDR_WIDTH(AW), .FIXED_PRIO(0)) dut0 (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rdata(rdata), .busy(busy),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   mem_arbiter #(.SIZE(SIZE), .ADDR_WIDTH(AW), .FIXED_PRIO(1)) dut1 (
      .clk(clk), .reset(reset),
      .req0(p_req0), .we0(1'b0), .addr0(16'h0003), .wdata0(16'h0000),
      .req1(p_req1), .we1(1'b0), .addr1(16'h0004), .wdata1(16'h0000),
      .gnt0(p_gnt0), .gnt1(p_gnt1), .ack0(p_ack0), .ack1(p_ack1),
      .rdata(p_rdata), .busy(p_busy),
      .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_din(p_mem_din), .mem_dout(p_mem_dout)
   );

   // write-first synchronous memories
   logic [SIZE-1:0] mem0 [256];
   logic [SIZE-1:0] mem1 [256];

   always @(posedge clk) begin
      if (mem_we) mem0[mem_addr[7:0]] <= mem_din;
      mem_dout <= mem_we ? mem_din : mem0[mem_addr[7:0]];
   end

   always @(posedge clk) begin
      if (p_mem_we) mem1[p_mem_addr[7:0]] <= p_mem_din;
      p_mem_dout <= p_mem_we ? p_mem_din : mem1[p_mem_addr[7:0]];
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   logic exp_sel;

   initial begin
      reset  = 1'b0;
      req0   = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1   = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      p_req0 = 1'b0; p_req1 = 1'b0;

      // reset held with a pending request
      req0 = 1'b1;
      repeat (3) tick();
      check("rst_gnt0",   32'(gnt0),     32'd0);
      check("rst_gnt1",   32'(gnt1),     32'd0);
      check("rst_ack0",   32'(ack0),     32'd0);
      check("rst_ack1",   32'(ack1),     32'd0);
      check("rst_mem_we", 32'(mem_we),   32'd0);
      check("rst_busy",   32'(busy),     32'd0);
      check("rst_addr",   32'(mem_addr), 32'd0);
      check("rst_din",    32'(mem_din),  32'd0);
      req0  = 1'b0;
      reset = 1'b1;
      tick();
      check("idle_busy", 32'(busy), 32'd0);

      // write 0x00A3 to 0x0005 via requester 0
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; wdata0 = 16'h00A3;
      tick();
      check("wr_mem_we",  32'(mem_we),   32'd1);
      check("wr_addr",    32'(mem_addr), 32'h0005);
      check("wr_din",     32'(mem_din),  32'h00A3);
      check("wr_gnt0",    32'(gnt0),     32'd1);
      check("wr_busy",    32'(busy),     32'd1);
      check("wr_ack0_e",  32'(ack0),     32'd0);
      tick();
      check("wr_we_drop", 32'(mem_we),   32'd0);
      check("wr_ack0",    32'(ack0),     32'd1);
      check("wr_gnt0_d",  32'(gnt0),     32'd1);
      check("wr_rdata",   32'(rdata),    32'h00A3);
      req0 = 1'b0;
      tick();
      check("wr_ack_end", 32'(ack0),     32'd0);
      check("wr_gnt_end", 32'(gnt0),     32'd0);
      check("wr_idle",    32'(busy),     32'd0);

      // read back 0x0005
      req0 = 1'b1; we0 = 1'b0;
      tick();
      check("rd_mem_we",  32'(mem_we), 32'd0);
      check("rd_ack_e",   32'(ack0),   32'd0);
      tick();
      check("rd_ack0",    32'(ack0),   32'd1);
      check("rd_rdata",   32'(rdata),  32'h00A3);
      req0 = 1'b0;
      tick();

      // tie after reset: 0,1,0,1 with one access every 3 cycles
      pulse_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0005;
      for (int k = 0; k < 4; k++) begin
         exp_sel = k[0];
         tick();
         check("tie_gnt0", 32'(gnt0), 32'(!exp_sel));
         check("tie_gnt1", 32'(gnt1), 32'(exp_sel));
         check("tie_noack", 32'(ack0 | ack1), 32'd0);
         tick();
         check("tie_ack0", 32'(ack0), 32'(!exp_sel));
         check("tie_ack1", 32'(ack1), 32'(exp_sel));
         check("tie_ovl",  32'(gnt0 & gnt1), 32'd0);
         check("tie_rdata", 32'(rdata), 32'h00A3);
         tick();
         check("tie_idle", 32'(busy), 32'd0);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      check("tie_stop", 32'(busy), 32'd0);

      // isolation: requester 1 inputs change during ACCESS
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0010; wdata1 = 16'h1234;
      tick();
      check("iso_gnt1", 32'(gnt1),     32'd1);
      check("iso_addr", 32'(mem_addr), 32'h0010);
      check("iso_din",  32'(mem_din),  32'h1234);
      addr1 = 16'h0099; wdata1 = 16'hFFFF;
      tick();
      check("iso_ack1",  32'(ack1),     32'd1);
      check("iso_addr2", 32'(mem_addr), 32'h0010);
      check("iso_rd",    32'(rdata),    32'h1234);
      req1 = 1'b0;
      tick();
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
      tick();
      tick();
      check("iso_rb_ack", 32'(ack1),  32'd1);
      check("iso_rb",     32'(rdata), 32'h1234);
      req1 = 1'b0;
      tick();

      // reset in the middle of an ACCESS
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0010; wdata1 = 16'h5555;
      tick();
      check("mid_we_pre", 32'(mem_we), 32'd1);
      reset = 1'b0;
      #1;
      check("mid_we",   32'(mem_we), 32'd0);
      check("mid_gnt1", 32'(gnt1),   32'd0);
      check("mid_busy", 32'(busy),   32'd0);
      tick();
      check("mid_noack", 32'(ack1), 32'd0);
      we1   = 1'b0;
      reset = 1'b1;
      tick();
      check("mid_regnt", 32'(gnt1), 32'd1);
      tick();
      check("mid_reack", 32'(ack1), 32'd1);
      req1 = 1'b0;
      tick();
      check("mid_end", 32'(busy), 32'd0);

      // fixed priority: requester 0 keeps winning while it holds req
      pulse_reset();
      p_req0 = 1'b1; p_req1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("fp_gnt0", 32'(p_gnt0), 32'd1);
         check("fp_gnt1", 32'(p_gnt1), 32'd0);
         tick();
         check("fp_ack0", 32'(p_ack0), 32'd1);
         check("fp_ack1", 32'(p_ack1), 32'd0);
         if (k == 2) p_req0 = 1'b0;
         tick();
      end
      tick();
      check("fp_late_gnt1", 32'(p_gnt1), 32'd1);
      check("fp_late_gnt0", 32'(p_gnt0), 32'd0);
      tick();
      check("fp_late_ack1", 32'(p_ack1), 32'd1);
      p_req1 = 1'b0;
      tick();
      check("fp_idle", 32'(p_busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
